muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Takes the two source operands read from the register file plus funct3, and returns a 32-bit result to the writeback mux.
- Multi-cycle. Core control stalls PC and register writes while busy && !done.

---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   clk, rst           - clock, synchronous active-high reset
//   start, funct3      - op request (sampled in IDLE) and RV32M funct3
//   operand_a/b        - rs1/rs2 values
//   busy, done, result - state != IDLE, one-cycle completion pulse, op result
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;      // negate product / quotient
  logic              neg_r;      // negate remainder
  logic [XLEN-1:0]   opnd;       // mul: |a| addend; div: |b| divisor
  logic [2*XLEN-1:0] acc;

  // Operand decode in IDLE
  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_sgn       = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_sgn       = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    sa          = a_sgn && operand_a[XLEN-1];
    sb          = b_sgn && operand_b[XLEN-1];
    mag_a       = sa ? -operand_a : operand_a;
    mag_b       = sb ? -operand_b : operand_b;
    div_zero    = funct3[2] && (operand_b == '0);
    div_ovf     = funct3[2] && !funct3[0] && (operand_a == MIN_INT) && (operand_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? operand_a : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : MIN_INT;
  end

  // One iteration step.
  // Multiply: acc = {partial high, remaining multiplier bits}, shift right each step.
  // Divide:   acc = {partial remainder, dividend/quotient bits}, shift left each step.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_fits;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_fits  = div_shift >= {1'b0, opnd};
    // Truncation is exact: when the divisor fits, the difference is below the divisor.
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (op_q[2])
      acc_next = div_fits ? {div_diff, acc[XLEN-2:0], 1'b1}
                          : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};
  end

  // Sign fix-up and result selection from the final iteration
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    prod = neg_q ? -acc_next : acc_next;
    quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem  = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        final_res = quo;
      default:               final_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= funct3;
            cnt   <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            opnd  <= funct3[2] ? mag_b : mag_a;
            acc   <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            if (special) begin
              result <= special_res;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            result <= final_res;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
